rnn_mem_host: RTL and testbench

//  Host-side counterpart of the RNN accelerator. It serves every accelerator memory access on the
//  mce/msel/maddr bus: weights, biases and the header are read-only to the accelerator, and the h-output bank is write-only.
//  It feeds the per-timestep input word on the ready/i_en/idata handshake, and gives a controller a load/readback port.

---
 rtl/rnn_mem_host.sv | 162 ++++++++++++++++
 tb/tb_rnn_mem_host.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/rnn_mem_host.sv
// rnn_mem_host: host-side memory and run control for the RNN core.
// Serves weights/biases/header/x to the core, captures its outputs.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   ld_we/ld_sel/ld_addr/ld_wdata/ld_rdata  controller load/readback
//   start/done/overrun/wr_count             run control and status
//   ready/busy/i_en/idata                   timestep input handshake
//   mce/msel/maddr/mdata_w/mdata_r          core memory bus
module rnn_mem_host #(
  parameter int T_MAX = 2048,
  parameter int DW    = 20
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_we,
  input  logic [2:0]    ld_sel,
  input  logic [16:0]   ld_addr,
  input  logic [31:0]   ld_wdata,
  output logic [31:0]   ld_rdata,
  input  logic          start,
  output logic          done,
  output logic          overrun,
  output logic [16:0]   wr_count,
  output logic          ready,
  input  logic          busy,
  input  logic          i_en,
  output logic [31:0]   idata,
  input  logic          mce,
  input  logic [2:0]    msel,
  input  logic [16:0]   maddr,
  input  logic [DW-1:0] mdata_w,
  output logic [DW-1:0] mdata_r
);

  localparam int OUT_D = 64 * T_MAX;
  localparam int OAW   = $clog2(OUT_D);
  localparam int XAW   = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  typedef enum logic [1:0] {
    IDLE, ARM, RUN, DONE
  } state_t;

  state_t state, state_nx;
  logic   busy_q;
  logic [16:0] x_idx;

  logic [DW-1:0] w_ih [2048];
  logic [DW-1:0] w_hh [4096];
  logic [DW-1:0] b_ih [64];
  logic [DW-1:0] b_hh [64];
  logic [DW-1:0] hdr;
  logic [DW-1:0] out_mem [OUT_D];
  logic [31:0]   x_mem [T_MAX];

  logic ld_ok, start_ok, x_ok, out_hit, out_ok;
  logic ld_out_ok, ld_x_ok;

  assign ld_ok     = (state == IDLE) || (state == DONE);
  assign start_ok  = start && ld_ok;
  assign x_ok      = 32'(x_idx) < 32'(T_MAX);
  assign out_hit   = (state == RUN) && mce && (msel == 3'b101);
  assign out_ok    = 32'(maddr) < 32'(OUT_D);
  assign ld_out_ok = 32'(ld_addr) < 32'(OUT_D);
  assign ld_x_ok   = 32'(ld_addr) < 32'(T_MAX);

  assign ready = (state == ARM);
  assign done  = (state == DONE);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE: if (start) state_nx = ARM;
      ARM:        if (busy) state_nx = RUN;
      RUN:        if (!busy && busy_q) state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy_q   <= 1'b0;
      overrun  <= 1'b0;
      wr_count <= '0;
      x_idx    <= '0;
    end else begin
      state  <= state_nx;
      busy_q <= busy;
      if (start_ok) begin
        overrun  <= 1'b0;
        wr_count <= '0;
        x_idx    <= '0;
      end else begin
        if (out_hit) begin
          if (out_ok) wr_count <= wr_count + 17'd1;
          else        overrun  <= 1'b1;
        end
        // index saturates at T_MAX so a long run cannot wrap back
        if (state == RUN && i_en) begin
          if (x_ok) x_idx   <= x_idx + 17'd1;
          else      overrun <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ld_we && ld_ok) begin
      unique case (ld_sel)
        3'b000: w_ih[ld_addr[10:0]] <= ld_wdata[DW-1:0];
        3'b001: b_ih[ld_addr[5:0]]  <= ld_wdata[DW-1:0];
        3'b010: w_hh[ld_addr[11:0]] <= ld_wdata[DW-1:0];
        3'b011: b_hh[ld_addr[5:0]]  <= ld_wdata[DW-1:0];
        3'b100: hdr <= ld_wdata[DW-1:0];
        3'b101: if (ld_out_ok)
                  out_mem[ld_addr[OAW-1:0]] <= ld_wdata[DW-1:0];
        3'b110: if (ld_x_ok)
                  x_mem[ld_addr[XAW-1:0]] <= ld_wdata;
        default: ;
      endcase
    end
    if (out_hit && out_ok)
      out_mem[maddr[OAW-1:0]] <= mdata_w;
  end

  always_comb begin
    idata = '0;
    if (x_ok) idata = x_mem[x_idx[XAW-1:0]];
  end

  // the core samples this a cycle after presenting maddr: no register
  always_comb begin
    mdata_r = '0;
    if (mce) begin
      unique case (msel)
        3'b000:  mdata_r = w_ih[maddr[10:0]];
        3'b010:  mdata_r = w_hh[maddr[11:0]];
        3'b001:  mdata_r = b_ih[maddr[5:0]];
        3'b011:  mdata_r = b_hh[maddr[5:0]];
        3'b100:  mdata_r = DW'(hdr[10:0]);
        default: mdata_r = '0;
      endcase
    end
  end

  always_comb begin
    ld_rdata = '0;
    unique case (ld_sel)
      3'b000:  ld_rdata = 32'(w_ih[ld_addr[10:0]]);
      3'b001:  ld_rdata = 32'(b_ih[ld_addr[5:0]]);
      3'b010:  ld_rdata = 32'(w_hh[ld_addr[11:0]]);
      3'b011:  ld_rdata = 32'(b_hh[ld_addr[5:0]]);
      3'b100:  ld_rdata = 32'(hdr);
      3'b101:  if (ld_out_ok)
                 ld_rdata = 32'(out_mem[ld_addr[OAW-1:0]]);
      3'b110:  if (ld_x_ok)
                 ld_rdata = x_mem[ld_addr[XAW-1:0]];
      default: ld_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_rnn_mem_host.sv
// tb_rnn_mem_host: scoreboard bench for rnn_mem_host.
// Directed vectors, expectations queued, negedge monitor compares.
module tb_rnn_mem_host;

  localparam int DW = 20;

  logic          clk = 1'b0;
  logic          reset;
  logic          ld_we;
  logic [2:0]    ld_sel;
  logic [16:0]   ld_addr;
  logic [31:0]   ld_wdata;
  logic [31:0]   ld_rdata;
  logic          start;
  logic          done;
  logic          overrun;
  logic [16:0]   wr_count;
  logic          ready;
  logic          busy;
  logic          i_en;
  logic [31:0]   idata;
  logic          mce;
  logic [2:0]    msel;
  logic [16:0]   maddr;
  logic [DW-1:0] mdata_w;
  logic [DW-1:0] mdata_r;

  rnn_mem_host #(.T_MAX(2), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .ld_we(ld_we), .ld_sel(ld_sel), .ld_addr(ld_addr),
    .ld_wdata(ld_wdata), .ld_rdata(ld_rdata),
    .start(start), .done(done), .overrun(overrun),
    .wr_count(wr_count), .ready(ready), .busy(busy),
    .i_en(i_en), .idata(idata), .mce(mce), .msel(msel),
    .maddr(maddr), .mdata_w(mdata_w), .mdata_r(mdata_r)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] v;
    string       nm;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] probe(input int id);
    case (id)
      0: return 32'(ready);
      1: return 32'(done);
      2: return 32'(overrun);
      3: return 32'(wr_count);
      4: return idata;
      5: return 32'(mdata_r);
      default: return ld_rdata;
    endcase
  endfunction

  task automatic expect_v(input int id, input logic [31:0] v,
                          input string nm);
    exp_t e;
    e.id = id; e.v = v; e.nm = nm;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] a;
      e = q.pop_front();
      a = probe(e.id);
      checks++;
      if (a !== e.v) begin
        errors++;
        $display("FAIL %s got %h want %h", e.nm, a, e.v);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1; ld_we = 0; ld_sel = 0; ld_addr = 0; ld_wdata = 0;
    start = 0; busy = 0; i_en = 0; mce = 0; msel = 0;
    maddr = 0; mdata_w = 0;
    step(); step();
    reset = 0;
    expect_v(0, 0, "rst_ready");
    expect_v(1, 0, "rst_done");
    expect_v(2, 0, "rst_overrun");
    expect_v(3, 0, "rst_wr_count");
    step();

    ld_we = 1; ld_sel = 3'b100; ld_addr = 0; ld_wdata = 32'd2;
    step();
    ld_sel = 3'b010; ld_addr = 17'h041; ld_wdata = 32'h0ABCD;
    step();
    ld_sel = 3'b110; ld_addr = 0; ld_wdata = 32'hDEADBEEF;
    step();
    ld_addr = 1; ld_wdata = 32'h12345678;
    step();
    ld_we = 0;

    ld_sel = 3'b010; ld_addr = 17'h041;
    expect_v(6, 32'h0ABCD, "ld_rb_whh");
    mce = 1; msel = 3'b010; maddr = 17'h041;
    expect_v(5, 32'h0ABCD, "mdata_whh");
    step();
    msel = 3'b100; maddr = 17'h1234;
    expect_v(5, 32'h00002, "mdata_hdr");
    step();
    msel = 3'b010; maddr = 17'h041; mce = 0;
    expect_v(5, 0, "mdata_mce0");
    step();

    start = 1;
    expect_v(0, 0, "ready_idle");
    step();
    start = 0;
    expect_v(0, 1, "ready_arm0");
    expect_v(4, 32'hDEADBEEF, "idata_arm");
    step();
    expect_v(0, 1, "ready_arm1");
    step();
    expect_v(0, 1, "ready_arm2");
    step();
    busy = 1;
    expect_v(0, 1, "ready_busy");
    step();
    expect_v(0, 0, "ready_run");

    expect_v(4, 32'hDEADBEEF, "idata_x0");
    i_en = 1;
    step();
    i_en = 0;
    expect_v(4, 32'h12345678, "idata_x1");
    step();

    mce = 1; msel = 3'b101; maddr = 17'h041; mdata_w = 20'hF0000;
    expect_v(3, 0, "wr_count_pre");
    expect_v(5, 0, "mdata_out_sel");
    step();
    mce = 0;
    ld_sel = 3'b101; ld_addr = 17'h041;
    expect_v(6, 32'h000F0000, "ld_rb_out");
    expect_v(3, 1, "wr_count_1");
    expect_v(2, 0, "overrun_clean");
    step();
    mce = 1; mdata_w = 20'h12345;
    expect_v(6, 32'h000F0000, "rb_old_value");
    step();
    mce = 0;
    expect_v(6, 32'h00012345, "rb_new_value");
    expect_v(3, 2, "wr_count_2");
    step();
    mce = 1; maddr = 17'h1FFFF; mdata_w = 20'h11111;
    step();
    mce = 0;
    expect_v(2, 1, "overrun_out");
    expect_v(3, 2, "wr_count_drop");
    step();

    ld_we = 1; ld_sel = 3'b010; ld_addr = 17'h041; ld_wdata = 32'h55555;
    step();
    ld_we = 0;
    expect_v(6, 32'h0ABCD, "ld_drop_run");
    busy = 0;
    expect_v(1, 0, "done_pre");
    step();
    expect_v(1, 1, "done_set");
    expect_v(0, 0, "ready_done");
    expect_v(2, 1, "overrun_sticky");
    step();
    expect_v(1, 1, "done_hold");
    step();

    start = 1;
    step();
    start = 0;
    expect_v(1, 0, "done_clr");
    expect_v(2, 0, "overrun_clr");
    expect_v(3, 0, "wr_count_clr");
    expect_v(4, 32'hDEADBEEF, "x_idx_clr");
    busy = 1;
    step();
    expect_v(0, 0, "ready_run2");
    step();
    reset = 1;
    step();
    reset = 0; busy = 0;
    expect_v(0, 0, "ready_reset");
    expect_v(1, 0, "done_reset");
    ld_sel = 3'b010; ld_addr = 17'h041;
    expect_v(6, 32'h0ABCD, "whh_kept");
    step();
    ld_we = 1; ld_sel = 3'b000; ld_addr = 17'h3; ld_wdata = 32'h777;
    step();
    ld_we = 0;
    expect_v(6, 32'h777, "ld_idle_ok");
    expect_v(0, 0, "ready_idle2");
    step();
    step();

    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
